// File: rtl/line_write_buffer_if.sv
// Line-granular handshake shared by the cache port and the main_mem port:
// the master drives addr/rd_req/wr_req/wr_line, the slave answers with rd_line and a one-cycle gnt.
interface line_write_buffer_if #(
  parameter int ADDR_LEN      = 9,
  parameter int LINE_ADDR_LEN = 3
);
  logic [ADDR_LEN-1:0]                   addr;
  logic                                  rd_req;
  logic                                  wr_req;
  logic [(2**LINE_ADDR_LEN)-1:0][31:0]   rd_line;
  logic [(2**LINE_ADDR_LEN)-1:0][31:0]   wr_line;
  logic                                  gnt;

  modport master (output addr, rd_req, wr_req, wr_line, input rd_line, gnt);
  modport slave  (input addr, rd_req, wr_req, wr_line, output rd_line, gnt);
endinterface

// File: rtl/line_write_buffer.sv
// Posted line write buffer between the data cache refill port and main_mem.
// Writebacks are acknowledged once buffered and drained in the background; refills check the buffer first.
module line_write_buffer #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9,
  parameter int DEPTH_LEN     = 2
) (
  input  logic                clk,
  input  logic                rst,
  line_write_buffer_if.slave  cache,
  line_write_buffer_if.master mem
);
  localparam int WORDS = 2**LINE_ADDR_LEN;
  localparam int DEPTH = 2**DEPTH_LEN;
  localparam logic [DEPTH_LEN:0] FULL_COUNT = (DEPTH_LEN+1)'(DEPTH);

  typedef logic [WORDS-1:0][31:0] line_t;
  typedef enum logic [1:0] {M_IDLE, M_READ, M_DRAIN} m_state_t;
  typedef enum logic {U_IDLE, U_WAIT_MEM} u_state_t;

  logic [DEPTH-1:0]    valid_r;
  logic [ADDR_LEN-1:0] addr_r [DEPTH];
  line_t               line_r [DEPTH];
  logic [DEPTH_LEN-1:0] head_r, tail_r;
  logic [DEPTH_LEN:0]  count_r;
  logic [ADDR_LEN-1:0] miss_addr_r;
  m_state_t            m_state_r;
  u_state_t            u_state_r;

  logic                gnt_r;
  line_t               rd_line_r;
  logic                mem_rd_req_r, mem_wr_req_r;
  logic [ADDR_LEN-1:0] mem_addr_r;
  line_t               mem_wr_line_r;

  logic                 head_lock_s, wr_hit_s, rd_hit_s;
  logic [DEPTH_LEN-1:0] wr_idx_s, rd_idx_s;
  logic                 pop_s, wr_accept_s, push_s, rd_eval_s;

  // Youngest-match search; the head is excluded from write coalescing while it is (or is about to be) drained.
  always_comb begin : match_search
    logic [DEPTH_LEN-1:0] idx;
    logic                 match;
    logic                 wr_ok;
    head_lock_s = (m_state_r == M_DRAIN) ||
                  ((m_state_r == M_IDLE) && (u_state_r != U_WAIT_MEM) && (count_r != '0));
    wr_hit_s = 1'b0;
    rd_hit_s = 1'b0;
    wr_idx_s = '0;
    rd_idx_s = '0;
    idx      = '0;
    match    = 1'b0;
    wr_ok    = 1'b0;
    for (int k = 32'sd0; k < DEPTH; k++) begin
      idx      = head_r + DEPTH_LEN'(k);
      match    = valid_r[idx] && (addr_r[idx] == cache.addr);
      wr_ok    = match && !((k == 32'sd0) && head_lock_s);
      rd_hit_s = rd_hit_s | match;
      rd_idx_s = match ? idx : rd_idx_s;
      wr_hit_s = wr_hit_s | wr_ok;
      wr_idx_s = wr_ok ? idx : wr_idx_s;
    end
  end

  // Request qualification: new requests are only looked at when idle and not in the gnt cycle.
  always_comb begin
    pop_s       = (m_state_r == M_DRAIN) && mem.gnt;
    wr_accept_s = (u_state_r == U_IDLE) && !gnt_r && cache.wr_req &&
                  (wr_hit_s || (count_r != FULL_COUNT) || pop_s);
    push_s      = wr_accept_s && !wr_hit_s;
    rd_eval_s   = (u_state_r == U_IDLE) && !gnt_r && !cache.wr_req && cache.rd_req;
  end

  // Entry payload storage; validity is tracked separately so reset only has to clear valid_r.
  always_ff @(posedge clk) begin
    if (wr_accept_s && wr_hit_s) begin
      line_r[wr_idx_s] <= cache.wr_line;
    end else if (push_s) begin
      addr_r[tail_r] <= cache.addr;
      line_r[tail_r] <= cache.wr_line;
    end
  end

  // Upstream and downstream FSMs, FIFO bookkeeping and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r       <= '0;
      head_r        <= '0;
      tail_r        <= '0;
      count_r       <= '0;
      miss_addr_r   <= '0;
      m_state_r     <= M_IDLE;
      u_state_r     <= U_IDLE;
      gnt_r         <= 1'b0;
      rd_line_r     <= '0;
      mem_rd_req_r  <= 1'b0;
      mem_wr_req_r  <= 1'b0;
      mem_addr_r    <= '0;
      mem_wr_line_r <= '0;
    end else begin
      gnt_r <= 1'b0;
      if (wr_accept_s) begin
        gnt_r <= 1'b1;
        if (push_s) tail_r <= tail_r + DEPTH_LEN'(1);
      end else if (rd_eval_s && rd_hit_s) begin
        gnt_r     <= 1'b1;
        rd_line_r <= line_r[rd_idx_s];
      end else if (rd_eval_s) begin
        miss_addr_r <= cache.addr;
        u_state_r   <= U_WAIT_MEM;
      end

      case (m_state_r)
        M_IDLE: begin
          if (u_state_r == U_WAIT_MEM) begin
            m_state_r    <= M_READ;
            mem_rd_req_r <= 1'b1;
            mem_addr_r   <= miss_addr_r;
          end else if (count_r != '0) begin
            m_state_r     <= M_DRAIN;
            mem_wr_req_r  <= 1'b1;
            mem_addr_r    <= addr_r[head_r];
            mem_wr_line_r <= line_r[head_r];
          end
        end
        M_READ: begin
          if (mem.gnt) begin
            rd_line_r    <= mem.rd_line;
            gnt_r        <= 1'b1;
            u_state_r    <= U_IDLE;
            mem_rd_req_r <= 1'b0;
            mem_addr_r   <= '0;
            m_state_r    <= M_IDLE;
          end
        end
        M_DRAIN: begin
          if (mem.gnt) begin
            head_r        <= head_r + DEPTH_LEN'(1);
            mem_wr_req_r  <= 1'b0;
            mem_addr_r    <= '0;
            mem_wr_line_r <= '0;
            m_state_r     <= M_IDLE;
          end
        end
        default: m_state_r <= M_IDLE;
      endcase

      // A pop and a push may hit the same slot when full; the push must win.
      if (pop_s) valid_r[head_r] <= 1'b0;
      if (push_s) valid_r[tail_r] <= 1'b1;

      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (DEPTH_LEN+1)'(1);
        2'b01:   count_r <= count_r - (DEPTH_LEN+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign cache.gnt     = gnt_r;
  assign cache.rd_line = rd_line_r;
  assign mem.rd_req    = mem_rd_req_r;
  assign mem.wr_req    = mem_wr_req_r;
  assign mem.addr      = mem_addr_r;
  assign mem.wr_line   = mem_wr_line_r;
endmodule

// File: tb/tb_line_write_buffer.sv
// Scoreboard bench for line_write_buffer: directed cache traffic against a stallable main_mem model.
module tb_line_write_buffer;
  typedef logic [7:0][31:0] line_t;
  typedef struct { logic is_wr; logic [8:0] addr; line_t line; } mexp_t;
  typedef struct { logic is_rd; line_t line; } gexp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_write_buffer_if #(.ADDR_LEN(9), .LINE_ADDR_LEN(3)) cache_if ();
  line_write_buffer_if #(.ADDR_LEN(9), .LINE_ADDR_LEN(3)) mem_if ();

  line_write_buffer #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .DEPTH_LEN(2)) dut (
    .clk(clk), .rst(rst), .cache(cache_if), .mem(mem_if)
  );

  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    credits = -1;
  int    last_mgnt = -1;
  int    last_rd_rise = -1;
  mexp_t mem_q[$];
  gexp_t gnt_q[$];
  line_t mem_store [512];

  function automatic line_t mk_line(input logic [31:0] base);
    line_t l;
    for (int i = 0; i < 8; i++) l[i] = base + 32'(i);
    return l;
  endfunction

  function automatic line_t mem_pattern(input logic [8:0] a);
    line_t l;
    for (int i = 0; i < 8; i++) l[i] = 32'h5000_0000 + (32'(a) << 8) + 32'(i);
    return l;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // main_mem model: answers after two cycles of a request, only while credits allow.
  initial begin : mem_model
    int age;
    age = 0;
    mem_if.gnt = 1'b0;
    mem_if.rd_line = '0;
    forever begin
      @(posedge clk); #1;
      if (rst || mem_if.gnt) begin
        mem_if.gnt = 1'b0;
        age = 0;
      end else if ((mem_if.rd_req || mem_if.wr_req) && credits != 0) begin
        age++;
        if (age >= 2) begin
          if (mem_if.rd_req) mem_if.rd_line = mem_pattern(mem_if.addr);
          else mem_store[mem_if.addr] = mem_if.wr_line;
          mem_if.gnt = 1'b1;
          age = 0;
          if (credits > 0) credits--;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Monitor for the main_mem side: every new request is matched against the expected queue.
  initial begin : mem_monitor
    logic prev_req, cur;
    mexp_t e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      cur = mem_if.rd_req | mem_if.wr_req;
      if (mem_if.rd_req && mem_if.wr_req) begin
        n_cmp++; n_fail++;
        $display("FAIL mem_req_exclusive: both mem_rd_req and mem_wr_req high at cycle %0d", cyc);
      end
      if (!cur && mem_if.addr != 9'h000) begin
        n_cmp++; n_fail++;
        $display("FAIL mem_addr_idle: got %h expected 000", mem_if.addr);
      end
      if (mem_if.gnt) last_mgnt = cyc;
      if (cur && !prev_req) begin
        if (mem_if.rd_req) last_rd_rise = cyc;
        if (mem_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL mem_unexpected: got rd=%0b wr=%0b addr=%h expected no request",
                   mem_if.rd_req, mem_if.wr_req, mem_if.addr);
        end else begin
          e = mem_q.pop_front();
          check("mem_req_kind", 256'(mem_if.wr_req), 256'(e.is_wr));
          check("mem_addr", 256'(mem_if.addr), 256'(e.addr));
          if (e.is_wr) check("mem_wr_line", mem_if.wr_line, e.line);
        end
      end
      prev_req = cur;
    end
  end

  // Monitor for the cache side: each gnt consumes one expected response.
  initial begin : gnt_monitor
    gexp_t g;
    forever begin
      @(negedge clk);
      if (!rst && cache_if.gnt) begin
        if (gnt_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL gnt_unexpected: got gnt=1 expected none at cycle %0d", cyc);
        end else begin
          g = gnt_q.pop_front();
          if (g.is_rd) check("rd_line", cache_if.rd_line, g.line);
        end
      end
    end
  end

  task automatic wait_gnt(output int gcyc);
    gcyc = -1;
    for (int n = 0; n < 300 && gcyc < 0; n++) begin
      @(negedge clk);
      if (cache_if.gnt) gcyc = cyc;
    end
    if (gcyc < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL gnt_timeout: got no gnt expected gnt within 300 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [8:0] a, input line_t l, output int icyc, output int gcyc);
    gnt_q.push_back('{1'b0, '0});
    icyc = cyc;
    cache_if.addr = a; cache_if.wr_line = l; cache_if.wr_req = 1'b1;
    wait_gnt(gcyc);
    cache_if.wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [8:0] a, input line_t exp, output int icyc, output int gcyc);
    gnt_q.push_back('{1'b1, exp});
    icyc = cyc;
    cache_if.addr = a; cache_if.rd_req = 1'b1;
    wait_gnt(gcyc);
    cache_if.rd_req = 1'b0;
  endtask

  task automatic wait_idle();
    int done;
    done = 0;
    for (int n = 0; n < 500 && done == 0; n++) begin
      @(negedge clk);
      if (mem_q.size() == 0 && gnt_q.size() == 0 && !mem_if.rd_req && !mem_if.wr_req) done = 1;
    end
    if (done == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: got %0d mem / %0d gnt pending expected 0", mem_q.size(), gnt_q.size());
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"}, 256'(cache_if.gnt), 256'(0));
    check({tag, "_rd_line"}, cache_if.rd_line, 256'(0));
    check({tag, "_mem_rd_req"}, 256'(mem_if.rd_req), 256'(0));
    check({tag, "_mem_wr_req"}, 256'(mem_if.wr_req), 256'(0));
    check({tag, "_mem_addr"}, 256'(mem_if.addr), 256'(0));
    check({tag, "_mem_wr_line"}, mem_if.wr_line, 256'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int ic, gc, g14, rel_cyc, mg_drain;
    line_t la, lx, ly, lc;
    rst = 1'b1;
    cache_if.addr = '0; cache_if.rd_req = 1'b0; cache_if.wr_req = 1'b0; cache_if.wr_line = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;

    // Single write into an empty buffer, then background drain.
    mem_q.push_back('{1'b1, 9'h012, mk_line(32'hDEAD0001)});
    do_write(9'h012, mk_line(32'hDEAD0001), ic, gc);
    check("wr_gnt_latency", 256'(gc - ic), 256'(1));
    wait_idle();
    check("drained_012", mem_store[9'h012], mk_line(32'hDEAD0001));

    // Fill the buffer with drain stalled; fifth write waits for a pop.
    credits = 0;
    for (int i = 0; i < 5; i++) mem_q.push_back('{1'b1, 9'h010 + 9'(i), mk_line(32'h1000_0000 + 32'(i << 8))});
    for (int i = 0; i < 4; i++) begin
      do_write(9'h010 + 9'(i), mk_line(32'h1000_0000 + 32'(i << 8)), ic, gc);
      check("fill_gnt_latency", 256'(gc - ic), 256'(1));
    end
    fork
      do_write(9'h014, mk_line(32'h1000_0400), ic, g14);
      begin
        repeat (6) @(posedge clk);
        #2 rel_cyc = cyc;
        credits = 1;
      end
    join
    check("full_no_early_gnt", 256'(g14 > rel_cyc), 256'(1));
    check("full_gnt_after_pop", 256'(g14), 256'(last_mgnt + 1));
    credits = -1;
    wait_idle();

    // Coalescing: the second write to 0x020 overwrites the queued entry behind the draining head.
    credits = 0;
    la = mk_line(32'hAAAA0000); lx = mk_line(32'h5858_0000); ly = mk_line(32'h5959_0000);
    mem_q.push_back('{1'b1, 9'h021, la});
    mem_q.push_back('{1'b1, 9'h020, ly});
    do_write(9'h021, la, ic, gc);
    do_write(9'h020, lx, ic, gc);
    do_write(9'h020, ly, ic, gc);
    check("coalesce_gnt_latency", 256'(gc - ic), 256'(1));
    credits = -1;
    wait_idle();
    check("drained_020", mem_store[9'h020], ly);

    // Read hit on the stalled draining head: no main_mem read.
    credits = 0;
    lc = mk_line(32'hCAFE0000);
    mem_q.push_back('{1'b1, 9'h030, lc});
    do_write(9'h030, lc, ic, gc);
    do_read(9'h030, lc, ic, gc);
    check("rd_hit_latency", 256'(gc - ic), 256'(1));
    credits = -1;
    wait_idle();

    // Read miss during an active drain waits for the drain's mem_gnt.
    credits = 0;
    mem_q.push_back('{1'b1, 9'h041, mk_line(32'h4141_0000)});
    mem_q.push_back('{1'b0, 9'h040, '0});
    do_write(9'h041, mk_line(32'h4141_0000), ic, gc);
    fork
      do_read(9'h040, mem_pattern(9'h040), ic, gc);
      begin
        repeat (4) @(posedge clk);
        #2 check("miss_waits_for_drain", 256'(mem_if.rd_req), 256'(0));
        credits = 1;
        repeat (6) @(posedge clk);
        #2 mg_drain = last_mgnt;
        check("miss_rd_after_drain", 256'(last_rd_rise > mg_drain), 256'(1));
        credits = 1;
      end
    join
    check("miss_gnt_after_mem_gnt", 256'(gc), 256'(last_mgnt + 1));
    credits = -1;
    wait_idle();

    // Reset in the middle of a drain with two entries buffered.
    credits = 0;
    mem_q.push_back('{1'b1, 9'h050, mk_line(32'h5050_0000)});
    do_write(9'h050, mk_line(32'h5050_0000), ic, gc);
    do_write(9'h051, mk_line(32'h5151_0000), ic, gc);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("midreset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    credits = -1;
    mem_q.push_back('{1'b0, 9'h050, '0});
    do_read(9'h050, mem_pattern(9'h050), ic, gc);
    wait_idle();

    check("mem_q_empty", 256'(mem_q.size()), 256'(0));
    check("gnt_q_empty", 256'(gnt_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
